// File: rtl/edge_pkg.sv
// Shared types and frame-geometry helpers for the edge-detection
// memory scheduler.
package edge_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        STREAM,
        DONE
    } sched_state_t;

    function automatic int row_width(input int w);
        return w / 4;
    endfunction

    function automatic int n_words(input int w, input int h);
        return (w * h) / 4;
    endfunction

    function automatic int out_base(input int w, input int h);
        return n_words(w, h);
    endfunction

endpackage

// File: rtl/edge_mem_sched_line_fifo.sv
// Row-delay line: dout is the word pushed DEPTH pushes ago, counting
// the push being presented now; zero until the line has filled.
module line_fifo #(
    parameter int DEPTH = 88,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    // The consumer's output register supplies the last stage of delay.
    localparam int N  = DEPTH - 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] buf_q [N];
    logic [PW-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else if (push) begin
            buf_q[ptr] <= din;
            ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
        end
    end

    assign dout = buf_q[ptr];

endmodule

// File: rtl/edge_mem_sched.sv
// Frame-memory scheduler and three-row stream builder.
// Optional cycle counter port when EDGE_SCHED_PERF_EN is defined.
module edge_mem_sched
    import edge_pkg::*;
#(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 288,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic [31:0]       acc_dataW,
    output logic              row_cached,
    output logic [31:0]       dataRa,
    output logic [31:0]       dataRb,
    output logic [31:0]       dataRc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [31:0]       mem_dataW,
    input  logic [31:0]       mem_dataR
`ifdef EDGE_SCHED_PERF_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RW_A = ADDR_W'(row_width(WIDTH));
    localparam logic [ADDR_W-1:0] NW_A = ADDR_W'(n_words(WIDTH, HEIGHT));
    localparam logic [ADDR_W-1:0] OB_A = ADDR_W'(out_base(WIDTH, HEIGHT));

    sched_state_t      state, state_nx;
    logic [ADDR_W-1:0] rd_addr, wr_cnt, prime_cnt;
    logic              rd_issue, zero_issue, wr_issue;
    logic              rd_valid, rd_zero;
    logic              frame_go;
    word_t             fifo_a_out, fifo_b_out;

    assign frame_go = (state == IDLE) && start;
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_dataW  = '0;
        rd_issue   = 1'b0;
        zero_issue = 1'b0;
        wr_issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = PREFETCH;
            end
            PREFETCH: begin
                rd_issue = 1'b1;
                mem_en   = 1'b1;
                mem_addr = rd_addr;
                if (rd_addr == RW_A) state_nx = STREAM;
            end
            STREAM: begin
                if (acc_en && !acc_we) begin
                    if (rd_addr < NW_A) begin
                        rd_issue = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = rd_addr;
                    end else begin
                        zero_issue = 1'b1;
                    end
                end else if (acc_en && acc_we && (wr_cnt < NW_A)) begin
                    wr_issue  = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = OB_A + wr_cnt;
                    mem_dataW = acc_dataW;
                    if (wr_cnt == NW_A - ADDR_W'(1)) state_nx = DONE;
                end
            end
            DONE: begin
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            wr_cnt  <= '0;
        end else if (frame_go) begin
            rd_addr <= '0;
            wr_cnt  <= '0;
        end else begin
            if (rd_issue) rd_addr <= rd_addr + ADDR_W'(1);
            if (wr_issue) wr_cnt  <= wr_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_zero  <= 1'b0;
        end else begin
            rd_valid <= rd_issue | zero_issue;
            rd_zero  <= zero_issue;
        end
    end

    // Bottom padding rows arrive as injected zero words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataRa     <= '0;
            dataRb     <= '0;
            dataRc     <= '0;
            prime_cnt  <= '0;
            row_cached <= 1'b0;
        end else if (frame_go) begin
            dataRa     <= '0;
            dataRb     <= '0;
            dataRc     <= '0;
            prime_cnt  <= '0;
            row_cached <= 1'b0;
        end else if ((state == DONE) && !start) begin
            row_cached <= 1'b0;
        end else if (rd_valid) begin
            dataRc <= rd_zero ? '0 : mem_dataR;
            dataRb <= fifo_b_out;
            dataRa <= fifo_a_out;
            if (prime_cnt != RW_A + ADDR_W'(1))
                prime_cnt <= prime_cnt + ADDR_W'(1);
            if (prime_cnt == RW_A) row_cached <= 1'b1;
        end
    end

    line_fifo #(
        .DEPTH(row_width(WIDTH)),
        .DW   (32)
    ) fifo_b (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_valid),
        .din  (dataRc),
        .dout (fifo_b_out)
    );

    line_fifo #(
        .DEPTH(row_width(WIDTH)),
        .DW   (32)
    ) fifo_a (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_valid),
        .din  (dataRb),
        .dout (fifo_a_out)
    );

`ifdef EDGE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_cnt <= '0;
        else if (frame_go)
            cycle_cnt <= '0;
        else if ((state == PREFETCH) || (state == STREAM))
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_edge_mem_sched.sv
// Directed bench for edge_mem_sched with a word-i-holds-i memory
// model of one-cycle read latency.
module tb_edge_mem_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        acc_en = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_dataW = '0;
    logic        done, row_cached, mem_en, mem_we;
    logic [31:0] dataRa, dataRb, dataRc, mem_dataW;
    logic [31:0] mem_dataR = '0;
    logic [15:0] mem_addr;
`ifdef EDGE_SCHED_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    int checks = 0;
    int failures = 0;

    edge_mem_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .acc_en    (acc_en),
        .acc_we    (acc_we),
        .acc_dataW (acc_dataW),
        .row_cached(row_cached),
        .dataRa    (dataRa),
        .dataRb    (dataRb),
        .dataRc    (dataRc),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_dataW (mem_dataW),
        .mem_dataR (mem_dataR)
`ifdef EDGE_SCHED_PERF_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en && !mem_we) mem_dataR <= 32'(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rc"}, 32'(row_cached), 32'd0);
        check({tag, "_ra"}, dataRa, 32'd0);
        check({tag, "_rb"}, dataRb, 32'd0);
        check({tag, "_rcw"}, dataRc, 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_en"}, 32'(mem_en), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_wd"}, mem_dataW, 32'd0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("idle_en", 32'(mem_en), 32'd0);
        end

        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i <= 88; i++) begin
            @(negedge clk);
            #1;
            check("pf_en", 32'(mem_en), 32'd1);
            check("pf_we", 32'(mem_we), 32'd0);
            check("pf_addr", 32'(mem_addr), 32'(i));
`ifdef EDGE_SCHED_PERF_EN
            check("pf_cyc", cycle_cnt, 32'(i));
`endif
        end
        @(negedge clk);
        #1;
        check("pf_stop_en", 32'(mem_en), 32'd0);
        check("pf_rc_early", 32'(row_cached), 32'd0);
        @(negedge clk);
        #1;
        check("prime_rc", 32'(row_cached), 32'd1);
        check("prime_ra", dataRa, 32'd0);
        check("prime_rb", dataRb, 32'd0);
        check("prime_rcw", dataRc, 32'd88);

        acc_en = 1'b1;
        acc_we = 1'b0;
        #1;
        check("rd1_en", 32'(mem_en), 32'd1);
        check("rd1_addr", 32'(mem_addr), 32'd89);
        @(negedge clk);
        acc_en = 1'b0;
        @(negedge clk);
        #1;
        check("rd1_rcw", dataRc, 32'd89);
        check("rd1_rb", dataRb, 32'd1);
        check("rd1_ra", dataRa, 32'd0);

        for (int i = 0; i < 88; i++) begin
            @(negedge clk);
            acc_en = 1'b1;
        end
        @(negedge clk);
        acc_en = 1'b0;
        @(negedge clk);
        #1;
        check("row2_rcw", dataRc, 32'd177);
        check("row2_rb", dataRb, 32'd89);
        check("row2_ra", dataRa, 32'd1);

        for (int i = 0; i < 25166; i++) begin
            @(negedge clk);
            acc_en = 1'b1;
        end
        @(negedge clk);
        #1;
        check("pad_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        acc_en = 1'b0;
        @(negedge clk);
        #1;
        check("pad_rcw", dataRc, 32'd0);
        check("pad_rb", dataRb, 32'd25256);
        check("pad_ra", dataRa, 32'd25168);

        @(negedge clk);
        acc_en = 1'b1;
        acc_we = 1'b1;
        acc_dataW = 32'hDEADBEEF;
        #1;
        check("wr1_en", 32'(mem_en), 32'd1);
        check("wr1_we", 32'(mem_we), 32'd1);
        check("wr1_addr", 32'(mem_addr), 32'd25344);
        check("wr1_data", mem_dataW, 32'hDEADBEEF);
        for (int i = 1; i < 25344; i++) begin
            @(negedge clk);
            acc_dataW = 32'(i);
        end
        #1;
        check("wr_last_addr", 32'(mem_addr), 32'd50687);
        check("wr_last_data", mem_dataW, 32'd25343);
        check("wr_last_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        check("done_set", 32'(done), 32'd1);
        check("done_wr_ignored", 32'(mem_we), 32'd0);
        acc_en = 1'b0;
        acc_we = 1'b0;
        @(negedge clk);
        #1;
        check("done_hold", 32'(done), 32'd1);
        check("done_rc_hold", 32'(row_cached), 32'd1);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_rc", 32'(row_cached), 32'd0);

        start = 1'b1;
        @(negedge clk);
        #1;
        check("f2_en", 32'(mem_en), 32'd1);
        check("f2_addr", 32'(mem_addr), 32'd0);
        repeat (95) @(negedge clk);
        acc_en = 1'b1;
        acc_we = 1'b1;
        acc_dataW = 32'h5;
        #1;
        check("f2_we", 32'(mem_we), 32'd1);
        check("f2_waddr", 32'(mem_addr), 32'd25344);
        check("f2_rc", 32'(row_cached), 32'd1);
        check("f2_rcw", dataRc, 32'd88);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
`ifdef EDGE_SCHED_PERF_EN
        check("mid_rst_cyc", cycle_cnt, 32'd0);
`endif
        @(negedge clk);
        acc_en = 1'b0;
        acc_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rs_en", 32'(mem_en), 32'd1);
        check("rs_addr", 32'(mem_addr), 32'd0);
`ifdef EDGE_SCHED_PERF_EN
        check("rs_cyc0", cycle_cnt, 32'd0);
`endif
        @(negedge clk);
        #1;
        check("rs_addr1", 32'(mem_addr), 32'd1);
`ifdef EDGE_SCHED_PERF_EN
        check("rs_cyc1", cycle_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
